// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU control codes shared across the execute stage
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b110;

    function automatic logic is_mul(input logic [2:0] alu_ctrl);
        return alu_ctrl == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: fixed-latency radix-2 shift-add multiplier that stalls EX until the product is ready
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q, result_q;
    logic               valid_q;
    logic [WIDTH-1:0]   acc_d;

    assign acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign stall_o  = (state_q == S_IDLE && start_i && !flush_i) || state_q == S_BUSY;
    assign busy_o   = state_q != S_IDLE;
    assign valid_o  = valid_q;
    assign result_o = result_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        acc_q    <= '0;
                        mcand_q  <= src1_i;
                        mplier_q <= src2_i;
                        cnt_q    <= CNT_MAX;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CNT_W'(1);
                        // last iteration: capture the final sum straight into the output register
                        if (cnt_q == '0) begin
                            result_q <= acc_d;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of latency, wrap-around, flush, back-to-back and async reset
module tb_mul_sequencer;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic             flush_i = 1'b0;
    logic [WIDTH-1:0] src1_i = '0;
    logic [WIDTH-1:0] src2_i = '0;
    logic             stall_o, valid_o, busy_o;
    logic [WIDTH-1:0] result_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .src1_i(src1_i), .src2_i(src2_i), .stall_o(stall_o), .valid_o(valid_o),
        .result_o(result_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one mul at the current negedge (cycle T); returns at the DONE cycle.
    task automatic do_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp);
        int stall_cycles;
        src1_i = a;
        src2_i = b;
        start_i = 1'b1;
        #1;
        check({tag, "_stall_T"}, {31'd0, stall_o}, 32'd1);
        check({tag, "_idle_T"}, {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        stall_cycles = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (stall_o && busy_o && !valid_o) stall_cycles++;
            if (i == 3) begin
                src1_i = ~a;
                src2_i = b ^ 32'hA5A5_5A5A;
            end
            @(negedge clk_i);
        end
        check({tag, "_busy_cycles"}, 32'(stall_cycles), 32'(WIDTH));
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        check({tag, "_result"}, result_o, exp);
    endtask

    initial begin
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_flags", {29'd0, stall_o, valid_o, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        do_mul("basic", 32'd3, 32'd5, 32'd15);
        @(negedge clk_i);
        check("basic_idle_after", {30'd0, busy_o, valid_o}, 32'd0);

        do_mul("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk_i);
        do_mul("wrap_16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        @(negedge clk_i);
        do_mul("signed", 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF2);
        @(negedge clk_i);
        do_mul("latched", 32'd1234, 32'd1000, 32'd1234000);
        @(negedge clk_i);

        // flush at BUSY cycle 10
        src1_i = 32'd11;
        src2_i = 32'd13;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("flush_busy_before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_idle", {30'd0, busy_o, stall_o}, 32'd0);
        begin
            int pulses = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid_o || busy_o) pulses++;
                @(negedge clk_i);
            end
            check("flush_no_valid", 32'(pulses), 32'd0);
        end
        check("flush_result_kept", result_o, 32'd1234000);

        // back-to-back: second mul enters the cycle after DONE
        do_mul("b2b_a", 32'd6, 32'd7, 32'd42);
        @(negedge clk_i);
        do_mul("b2b_b", 32'd9, 32'd9, 32'd81);
        @(negedge clk_i);

        // asynchronous reset at BUSY cycle 5, between edges
        src1_i = 32'd77;
        src2_i = 32'd88;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_flags", {29'd0, stall_o, valid_o, busy_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        do_mul("post_rst", 32'd100, 32'd200, 32'd20000);
        @(negedge clk_i);
        check("post_rst_idle", {31'd0, busy_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiplier controller for the execute stage. When ALU control selects the multiply code, this block takes the two operands, runs a fixed-latency radix-2 multiply and stalls the pipeline until the result is ready. It then hands back the low WIDTH bits of the product in place of the combinational ALU result. It sits beside the ALU in EX and drives the pipeline-wide stall used by the hazard logic.

## Interface
- WIDTH, 32, operand and result width in bits
- CNT_W, $clog2(WIDTH), width of the iteration counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  EX holds a valid mul instruction (ALU control code 3'b110)
- flush_i  in  1  EX instruction squashed; abort any multiply in progress
- src1_i  in  WIDTH  multiplicand (rs value)
- src2_i  in  WIDTH  multiplier (rt value)
- stall_o  out  1  freeze IF/ID/EX; combinational
- valid_o  out  1  result_o is the product of the current mul; 1-cycle pulse
- result_o  out  WIDTH  low WIDTH bits of src1*src2
- busy_o  out  1  state is not IDLE

## Operation
- States:
  - IDLE: waiting for a mul.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE, start_i=1, flush_i=0:
  - latch acc=0, mcand=src1_i, mplier=src2_i, cnt=WIDTH-1.
  - Next state BUSY.
- BUSY, each cycle:
  - if mplier[0] then acc = acc + mcand, modulo 2^WIDTH.
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - Leave for DONE in the cycle cnt==0; this is the WIDTH-th iteration.
- DONE:
  - result_o = acc; valid_o = 1.
  - Next state IDLE unconditionally. start_i is ignored in DONE, because the instruction still in EX is the one just finished.
- Fixed latency; no early termination on a zero multiplier.
- Signed and unsigned operands give the same low WIDTH bits, so there is no sign handling.
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. stall_o is 0 in DONE, so the pipeline advances at the end of DONE.
- Flush:
  - flush_i=1 in BUSY or DONE forces IDLE next cycle with no valid_o.
  - flush_i takes priority over start_i in IDLE.
  - result_o keeps its previous value.
- result_o is registered and holds its last value until the next DONE.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, cnt=0, acc/mcand/mplier=0. Outputs: result_o=0, valid_o=0, busy_o=0, stall_o=0 (given start_i=0).
- Reset mid-multiply: the operation is lost and outputs return to reset values immediately. After release, the block is in IDLE.
- Latency for start_i sampled high at edge T (cycle T):
  - BUSY during cycles T+1 .. T+WIDTH.
  - DONE with valid_o=1 in cycle T+WIDTH+1.
  - stall_o is high for cycles T .. T+WIDTH, i.e. WIDTH+1 cycles.
- Back-to-back muls: a second mul enters EX in the cycle after DONE. It is accepted from IDLE, so there is a 1-cycle gap between the two stall windows.
- Input sampling: src1_i/src2_i are sampled only at acceptance. Later changes have no effect.

## Structure
- Shared package, cpu_pkg: ALU control codes ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_MUL=3'b110. start_i is generated in EX by comparing against ALU_MUL.
- State encoding is local to this module: 2-bit IDLE=0, BUSY=1, DONE=2; code 3 recovers to IDLE.
- No sub-module. Counter, shift registers and accumulator are local to this block.

## Test plan
- Basic multiply:
  - Stimulus: src1=3, src2=5, start at T.
  - Response: stall_o high T..T+32; valid_o pulse at T+33 with result_o=15; busy_o low at T+34.
- Wrap-around:
  - Stimulus: src1=src2=32'hFFFFFFFF.
  - Response: result_o=32'h00000001.
  - Stimulus: src1=src2=32'h00010000.
  - Response: result_o=32'h00000000.
- Signed operands:
  - Stimulus: src1=32'hFFFFFFFE (-2), src2=7.
  - Response: result_o=32'hFFFFFFF2 (-14).
- Operand change mid-operation:
  - Stimulus: alter src1_i/src2_i during BUSY.
  - Response: result reflects the values latched at start.
- Flush and back-to-back:
  - Stimulus: flush_i at BUSY cycle 10.
  - Response: IDLE next cycle, no valid_o, result_o unchanged.
  - Stimulus: two muls issued back-to-back (6*7, then 9*9).
  - Response: 42 then 81, with a 1-cycle stall gap between them.
- Reset mid-multiply:
  - Stimulus: assert rst_i low at BUSY cycle 5, asynchronously between edges.
  - Response: busy_o and stall_o drop without waiting for a clock edge, result_o=0. A new mul after release completes normally.
